// File: rtl/crc32_byte_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : crc32_byte_serializer                                         |
// | Purpose  : byte-stream to bit-serial framer for a serial CRC-32 engine.  |
// |            Optional CRC append path enabled by CRC32_SER_APPEND_EN.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module crc32_byte_serializer #(
    parameter int LSB_FIRST = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             load,
    output logic             crc_in,
    output logic             bit_valid,
    output logic             d_finish,
    output logic [CNT_W-1:0] byte_count,
`ifdef CRC32_SER_APPEND_EN
    input  logic [31:0]      crc_res,
    output logic             crc_res_ready,
`endif
    output logic             underrun
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SHIFT  = 3'd2,
        S_WAIT   = 3'd3,
        S_FIN    = 3'd4,
        S_APPEND = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_byte, w_byte_nxt;
    logic             r_last, w_last_nxt;
    logic [2:0]       r_cnt, w_cnt_nxt, w_bit_idx;
    logic [CNT_W-1:0] r_byte_count, w_byte_count_nxt, w_count_inc;
    logic             r_underrun, w_underrun_nxt;
    logic             r_load, r_crc_in, r_bit_valid, r_d_finish;
    logic             w_crc_in_nxt, w_finish_nxt;
    logic             w_ready, w_accept;
`ifdef CRC32_SER_APPEND_EN
    logic [5:0]       r_app_cnt, w_app_cnt_nxt;
    logic [31:0]      r_sr, w_sr_nxt;
    logic             r_crc_res_ready;
`endif

    // Ready is the only combinational output; forced low during reset.
    always_comb begin
        w_ready = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE, S_WAIT: w_ready = 1'b1;
                S_SHIFT:        w_ready = (r_cnt == 3'd7) && !r_last;
                default:        w_ready = 1'b0;
            endcase
        end
    end

    assign w_accept    = in_valid && w_ready;
    assign w_count_inc = (r_byte_count == c_cnt_max) ? r_byte_count
                                                     : r_byte_count + CNT_W'(1);

    always_comb begin
        w_state_nxt      = r_state;
        w_byte_nxt       = r_byte;
        w_last_nxt       = r_last;
        w_cnt_nxt        = r_cnt;
        w_byte_count_nxt = r_byte_count;
        w_underrun_nxt   = r_underrun;
        w_crc_in_nxt     = 1'b0;
        w_bit_idx        = 3'd0;
`ifdef CRC32_SER_APPEND_EN
        w_app_cnt_nxt    = r_app_cnt;
        w_sr_nxt         = r_sr;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_byte_nxt       = in_data;
                    w_last_nxt       = in_last;
                    w_byte_count_nxt = CNT_W'(1);
                    w_underrun_nxt   = 1'b0;
                    w_state_nxt      = S_LOAD;
                end
            end
            S_LOAD: begin
                w_cnt_nxt   = 3'd0;
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt != 3'd7) begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end else if (r_last) begin
`ifdef CRC32_SER_APPEND_EN
                    w_app_cnt_nxt = 6'd0;
                    w_state_nxt   = S_APPEND;
`else
                    w_state_nxt   = S_FIN;
`endif
                end else if (w_accept) begin
                    // Gapless hand-over: next byte starts on the very next cycle.
                    w_byte_nxt       = in_data;
                    w_last_nxt       = in_last;
                    w_byte_count_nxt = w_count_inc;
                    w_cnt_nxt        = 3'd0;
                end else begin
                    w_underrun_nxt = 1'b1;
                    w_state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_accept) begin
                    w_byte_nxt       = in_data;
                    w_last_nxt       = in_last;
                    w_byte_count_nxt = w_count_inc;
                    w_cnt_nxt        = 3'd0;
                    w_state_nxt      = S_SHIFT;
                end
            end
`ifdef CRC32_SER_APPEND_EN
            S_APPEND: begin
                // Count 0 is the handshake cycle; counts 1..32 carry CRC bits.
                if (r_app_cnt == 6'd0) begin
                    w_sr_nxt     = {crc_res[30:0], 1'b0};
                    w_crc_in_nxt = crc_res[31];
                end else if (r_app_cnt != 6'd32) begin
                    w_sr_nxt     = {r_sr[30:0], 1'b0};
                    w_crc_in_nxt = r_sr[31];
                end
                if (r_app_cnt == 6'd32) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_app_cnt_nxt = r_app_cnt + 6'd1;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_state_nxt == S_SHIFT) begin
            w_bit_idx    = (LSB_FIRST != 0) ? w_cnt_nxt : 3'd7 - w_cnt_nxt;
            w_crc_in_nxt = w_byte_nxt[w_bit_idx];
        end
    end

`ifdef CRC32_SER_APPEND_EN
    assign w_finish_nxt = (w_state_nxt == S_APPEND) && (w_app_cnt_nxt == 6'd0);
`else
    assign w_finish_nxt = (w_state_nxt == S_FIN);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_byte          <= 8'd0;
            r_last          <= 1'b0;
            r_cnt           <= 3'd0;
            r_byte_count    <= '0;
            r_underrun      <= 1'b0;
            r_load          <= 1'b0;
            r_crc_in        <= 1'b0;
            r_bit_valid     <= 1'b0;
            r_d_finish      <= 1'b0;
`ifdef CRC32_SER_APPEND_EN
            r_app_cnt       <= 6'd0;
            r_sr            <= 32'd0;
            r_crc_res_ready <= 1'b0;
`endif
        end else begin
            r_state         <= w_state_nxt;
            r_byte          <= w_byte_nxt;
            r_last          <= w_last_nxt;
            r_cnt           <= w_cnt_nxt;
            r_byte_count    <= w_byte_count_nxt;
            r_underrun      <= w_underrun_nxt;
            r_load          <= (w_state_nxt == S_LOAD);
            r_crc_in        <= w_crc_in_nxt;
            r_bit_valid     <= (w_state_nxt == S_SHIFT);
            r_d_finish      <= w_finish_nxt;
`ifdef CRC32_SER_APPEND_EN
            r_app_cnt       <= w_app_cnt_nxt;
            r_sr            <= w_sr_nxt;
            r_crc_res_ready <= w_finish_nxt;
`endif
        end
    end

    assign in_ready   = w_ready;
    assign load       = r_load;
    assign crc_in     = r_crc_in;
    assign bit_valid  = r_bit_valid;
    assign d_finish   = r_d_finish;
    assign byte_count = r_byte_count;
    assign underrun   = r_underrun;
`ifdef CRC32_SER_APPEND_EN
    assign crc_res_ready = r_crc_res_ready;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crc32_byte_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_crc32_byte_serializer                                      |
// | Purpose  : frame-level bench for crc32_byte_serializer (MSB-first and    |
// |            LSB-first instances sharing one input stream).                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_crc32_byte_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid, in_last;
    logic        rdy0, ld0, ci0, bv0, fin0, ur0;
    logic [15:0] bc0;
    logic        rdy1, ld1, ci1, bv1, fin1, ur1;
    logic [2:0]  bc1;

    always #5 clk = ~clk;

    crc32_byte_serializer #(.LSB_FIRST(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rdy0), .load(ld0), .crc_in(ci0),
        .bit_valid(bv0), .d_finish(fin0), .byte_count(bc0), .underrun(ur0)
    );

    crc32_byte_serializer #(.LSB_FIRST(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rdy1), .load(ld1), .crc_in(ci1),
        .bit_valid(bv1), .d_finish(fin1), .byte_count(bc1), .underrun(ur1)
    );

    // One entry per clock cycle: inputs to drive and outputs expected.
    typedef struct packed {
        logic        rst, v, l;
        logic [7:0]  d;
        logic        rdy, ld, bv, c0, c1, fin, ur;
        logic [15:0] bc0;
        logic [2:0]  bc1;
    } cyc_t;

    cyc_t        trace[$];
    logic [15:0] m_bc0;
    logic [2:0]  m_bc1;
    logic        m_ur;
    logic [7:0]  fb[$];
    int          fg[$];
    int          checks = 0;
    int          errors = 0;

    task automatic add(input logic r, input logic v, input logic l, input logic [7:0] d,
                       input logic rdy, input logic ld, input logic bv,
                       input logic [7:0] b, input logic [2:0] k, input logic fin);
        cyc_t c;
        c.rst = r;  c.v = v;  c.l = l;  c.d = d;
        c.rdy = rdy; c.ld = ld; c.bv = bv; c.fin = fin;
        c.c0  = bv ? b[3'd7 - k] : 1'b0;
        c.c1  = bv ? b[k] : 1'b0;
        c.ur  = m_ur; c.bc0 = m_bc0; c.bc1 = m_bc1;
        trace.push_back(c);
    endtask

    task automatic bump();
        m_bc0 = (m_bc0 == 16'hFFFF) ? m_bc0 : m_bc0 + 16'd1;
        m_bc1 = (m_bc1 == 3'd7) ? m_bc1 : m_bc1 + 3'd1;
    endtask

    // Frame in fb/fg: fg[0] idle cycles before the first byte, fg[i] cycles
    // the byte i is late relative to the bit-7 cycle of byte i-1. With eager
    // set, in_valid stays high with the next pending byte while not ready.
    task automatic build_frame(input logic eager, input logic [7:0] nxt);
        int         n;
        logic [7:0] pd;
        logic       pl;
        n = fb.size();
        for (int j = 0; j < fg[0]; j++) add(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 3'd0, 0);
        add(0, 1, (n == 1), fb[0], 1, 0, 0, 8'h00, 3'd0, 0);
        m_bc0 = 16'd1; m_bc1 = 3'd1; m_ur = 1'b0;
        pd = (n > 1) ? fb[1] : nxt;
        pl = (n == 2);
        add(0, eager, pl, pd, 0, 1, 0, 8'h00, 3'd0, 0);
        for (int i = 0; i < n; i++) begin
            pd = (i + 1 < n) ? fb[i+1] : nxt;
            pl = (i + 1 == n - 1);
            for (int k = 0; k < 8; k++) begin
                if (k < 7 || i == n - 1) begin
                    add(0, eager, pl, pd, 0, 0, 1, fb[i], 3'(k), 0);
                end else if (fg[i+1] == 0) begin
                    add(0, 1, pl, pd, 1, 0, 1, fb[i], 3'd7, 0);
                    bump();
                end else begin
                    add(0, 0, 0, 8'h00, 1, 0, 1, fb[i], 3'd7, 0);
                    m_ur = 1'b1;
                    for (int j = 0; j < fg[i+1] - 1; j++) add(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 3'd0, 0);
                    add(0, 1, pl, pd, 1, 0, 0, 8'h00, 3'd0, 0);
                    bump();
                end
            end
        end
        add(0, eager, 1'b0, nxt, 0, 0, 0, 8'h00, 3'd0, 1);
        fb.delete();
        fg.delete();
    endtask

    // Single-byte frame killed by a one-cycle reset during bit 4.
    task automatic build_abort(input logic [7:0] b);
        add(0, 1, 1, b, 1, 0, 0, 8'h00, 3'd0, 0);
        m_bc0 = 16'd1; m_bc1 = 3'd1; m_ur = 1'b0;
        add(0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 3'd0, 0);
        for (int k = 0; k < 4; k++) add(0, 0, 0, 8'h00, 0, 0, 1, b, 3'(k), 0);
        add(1, 0, 0, 8'h00, 0, 0, 1, b, 3'd4, 0);
        m_bc0 = 16'd0; m_bc1 = 3'd0; m_ur = 1'b0;
    endtask

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        m_bc0 = 16'd0; m_bc1 = 3'd0; m_ur = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", -1, {31'd0, rdy0}, 32'd0);
        chk("rst_ready1", -1, {31'd0, rdy1}, 32'd0);
        chk("rst_ctl0", -1, {26'd0, ld0, ci0, bv0, fin0, ur0, 1'b0}, 32'd0);
        chk("rst_ctl1", -1, {26'd0, ld1, ci1, bv1, fin1, ur1, 1'b0}, 32'd0);
        chk("rst_bc0", -1, {16'd0, bc0}, 32'd0);
        chk("rst_bc1", -1, {29'd0, bc1}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready0", -1, {31'd0, rdy0}, 32'd1);
        chk("idle_ready1", -1, {31'd0, rdy1}, 32'd1);

        fb = '{8'hA5};             fg = '{2};    build_frame(0, 8'h00);
        fb = '{8'h01, 8'h80};      fg = '{1, 0}; build_frame(0, 8'h00);
        fb = '{8'hC3, 8'h5A};      fg = '{0, 3}; build_frame(0, 8'h00);
        fb = '{8'h0F};             fg = '{1};    build_frame(0, 8'h00);
        build_abort(8'h96);
        fb = '{8'h3C};             fg = '{1};    build_frame(1, 8'h7E);
        fb = '{8'h7E, 8'h11};      fg = '{0, 0}; build_frame(0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            fb.push_back(8'($urandom));
            fg.push_back(0);
        end
        fg[0] = 1;
        build_frame(1, 8'h00);
        for (int f = 0; f < 4; f++) begin
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) begin
                fb.push_back(8'($urandom));
                fg.push_back(int'($urandom_range(0, 2)));
            end
            build_frame(0, 8'h00);
        end

        foreach (trace[i]) begin
            @(posedge clk); #1;
            rst      = trace[i].rst;
            in_valid = trace[i].v;
            in_last  = trace[i].l;
            in_data  = trace[i].d;
            @(negedge clk);
            chk("ctl0", i, {26'd0, rdy0, ld0, bv0, ci0, fin0, ur0},
                {26'd0, trace[i].rdy, trace[i].ld, trace[i].bv, trace[i].c0, trace[i].fin, trace[i].ur});
            chk("ctl1", i, {26'd0, rdy1, ld1, bv1, ci1, fin1, ur1},
                {26'd0, trace[i].rdy, trace[i].ld, trace[i].bv, trace[i].c1, trace[i].fin, trace[i].ur});
            chk("bc0", i, {16'd0, bc0}, {16'd0, trace[i].bc0});
            chk("bc1", i, {29'd0, bc1}, {29'd0, trace[i].bc1});
        end
        rst = 1'b0; in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
